// File: rtl/alu_sched_pkg.sv
// alu_sched shared types: FSM states, ALU op codes and the latched request.
// Optional 64-bit chaining is enabled with ALU_SCHED_WIDE_EN.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2,
    HI_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        id;
    logic        wide;
  } req_t;

endpackage

// File: rtl/alu32.sv
// Shared 32-bit ALU: {s1,s0} = 00 add, 01 sub (a + ~b + carryin), 10 and, 11 or.
// Logic ops report cout = 0.
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s1,
  input  logic        s0,
  input  logic        carryin,
  output logic [31:0] out,
  output logic        cout,
  output logic        zout
);

  logic [31:0] bx;
  logic [32:0] sum;

  always_comb begin
    bx   = s0 ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bx} + {32'd0, carryin};
    out  = sum[31:0];
    cout = sum[32];
    if (s1) begin
      out  = s0 ? (a | b) : (a & b);
      cout = 1'b0;
    end
    zout = (out == 32'd0);
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant moves only when advance is high.
// Requester 0 wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      valid[0] && (!valid[1] || last_grant): grant = 2'b01;
      valid[1] && (!valid[0] || !last_grant): grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu32 between two requesters.
// ALU_SCHED_WIDE_EN adds 64-bit add/sub as two chained beats.
module alu_sched
  import alu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  input  logic [1:0]  req_cin,
`ifdef ALU_SCHED_WIDE_EN
  input  logic [1:0]  req_wide,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_out,
  output logic        rsp_cout,
  output logic        rsp_zout,
  output logic        rsp_last
);

  state_t      state, nxt;
  req_t        cur;
  logic [1:0]  grant;
  logic        adv;
  logic        sel;
  logic [31:0] pa, pb;
  logic [31:0] alu_out;
  logic        alu_c, alu_z;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (adv),
    .grant   (grant)
  );

  alu32 u_alu (
    .a       (cur.a),
    .b       (cur.b),
    .s1      (cur.op[1]),
    .s0      (cur.op[0]),
    .carryin (cur.cin),
    .out     (alu_out),
    .cout    (alu_c),
    .zout    (alu_z)
  );

  assign sel = (state == IDLE) ? grant[1] : cur.id;
  assign pa  = sel ? req_a1 : req_a0;
  assign pb  = sel ? req_b1 : req_b0;

  assign rsp_valid = (state == RESP);

  always_comb begin
    nxt       = state;
    req_ready = 2'b00;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          adv = 1'b1;
          nxt = EXEC;
        end
      end
      EXEC: nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
`ifdef ALU_SCHED_WIDE_EN
          nxt = cur.wide ? HI_WAIT : IDLE;
`else
          nxt = IDLE;
`endif
        end
      end
`ifdef ALU_SCHED_WIDE_EN
      HI_WAIT: begin
        // Locked to the low-beat owner; the other side stalls.
        req_ready = {cur.id, ~cur.id} & req_valid;
        if (|req_ready) nxt = EXEC;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

`ifdef ALU_SCHED_WIDE_EN
  logic hi;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
`ifdef ALU_SCHED_WIDE_EN
      hi  <= 1'b0;
`endif
    end else if (state == IDLE && |grant) begin
      cur.a   <= pa;
      cur.b   <= pb;
      cur.op  <= grant[1] ? req_op1 : req_op0;
      cur.cin <= grant[1] ? req_cin[1] : req_cin[0];
      cur.id  <= grant[1];
`ifdef ALU_SCHED_WIDE_EN
      cur.wide <= grant[1] ? req_wide[1] : req_wide[0];
      hi       <= 1'b0;
    end else if (state == HI_WAIT && |req_ready) begin
      // rsp_cout still holds the low-beat carry here.
      cur.a    <= pa;
      cur.b    <= pb;
      cur.cin  <= rsp_cout;
      cur.wide <= 1'b0;
      hi       <= 1'b1;
`else
      cur.wide <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_out  <= '0;
      rsp_cout <= 1'b0;
      rsp_zout <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id   <= cur.id;
      rsp_out  <= alu_out;
      rsp_cout <= alu_c;
`ifdef ALU_SCHED_WIDE_EN
      rsp_zout <= hi ? (alu_z & rsp_zout) : alu_z;
`else
      rsp_zout <= alu_z;
`endif
    end
  end

`ifdef ALU_SCHED_WIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_last <= 1'b0;
    else if (state == EXEC)  rsp_last <= ~cur.wide;
  end
`else
  // wide is never set in this build, so this is constant 1.
  assign rsp_last = ~cur.wide;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched.
// Wide-beat scenarios run only when ALU_SCHED_WIDE_EN is defined.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_op0, req_op1, req_cin;
`ifdef ALU_SCHED_WIDE_EN
  logic [1:0]  req_wide;
  localparam logic RST_LAST = 1'b0;
`else
  localparam logic RST_LAST = 1'b1;
`endif
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zout, rsp_last;
  logic [31:0] rsp_out;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_cin   (req_cin),
`ifdef ALU_SCHED_WIDE_EN
    .req_wide  (req_wide),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_cout  (rsp_cout),
    .rsp_zout  (rsp_zout),
    .rsp_last  (rsp_last)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = OP_ADD; req_op1 = OP_ADD; req_cin = 2'b00;
`ifdef ALU_SCHED_WIDE_EN
    req_wide = 2'b00;
`endif
    rsp_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zout} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zout});
    end
    checks++;
    if (rsp_out !== 32'd0) begin
      errs++;
      $display("FAIL reset_out got=%h exp=0", rsp_out);
    end
    checks++;
    if (rsp_last !== RST_LAST) begin
      errs++;
      $display("FAIL reset_last got=%b exp=%b", rsp_last, RST_LAST);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single;
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
    req_op0 = OP_ADD; req_cin = 2'b00;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_t1 got=%b exp=0", rsp_valid);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_out, rsp_cout, rsp_zout, rsp_id, rsp_last}
        !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL single_rsp got v=%b out=%h c=%b z=%b id=%b l=%b exp v=1 out=0 c=1 z=1 id=0 l=1",
               rsp_valid, rsp_out, rsp_cout, rsp_zout, rsp_id, rsp_last);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_done got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_ops;
    logic [31:0] ta [3] = '{32'd3, 32'hF0F0_00FF, 32'd5};
    logic [31:0] tb [3] = '{32'd5, 32'h0FF0_0F0F, 32'd5};
    logic [1:0]  top [3] = '{OP_SUB, OP_AND, OP_SUB};
    logic [31:0] eo [3] = '{32'hFFFF_FFFE, 32'h00F0_000F, 32'd0};
    logic [1:0]  ecz [3] = '{2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 3; i++) begin
      req_a0 = ta[i]; req_b0 = tb[i]; req_op0 = top[i];
      req_cin = 2'b01;
      req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      cyc();
      checks++;
      if ({rsp_valid, rsp_out, rsp_cout, rsp_zout} !== {1'b1, eo[i], ecz[i]}) begin
        errs++;
        $display("FAIL ops_%0d got v=%b out=%h cz=%b%b exp v=1 out=%h cz=%b",
                 i, rsp_valid, rsp_out, rsp_cout, rsp_zout, eo[i], ecz[i]);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
    end
    req_cin = 2'b00;
  endtask

  task automatic test_fairness;
    int n = 0;
    pulse_reset();
    req_a0 = 32'd10; req_b0 = 32'd1; req_op0 = OP_ADD;
    req_a1 = 32'd20; req_b1 = 32'd2; req_op1 = OP_ADD;
    req_cin = 2'b00;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      cyc();
      if (rsp_valid) begin
        checks++;
        if ({rsp_id, rsp_out} !== {n[0], (n[0] ? 32'd22 : 32'd11)}) begin
          errs++;
          $display("FAIL fair_%0d got id=%b out=%0d exp id=%b out=%0d",
                   n, rsp_id, rsp_out, n[0], n[0] ? 22 : 11);
        end
        n++;
      end
    end
    req_valid = 2'b00;
    checks++;
    if (n != 4) begin
      errs++;
      $display("FAIL fair_timeout got=%0d responses exp=4", n);
    end
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic ok = 1'b1;
    req_a1 = 32'd5; req_b1 = 32'd7; req_op1 = OP_ADD;
    req_valid = 2'b10;
    cyc();
    req_a0 = 32'd100; req_b0 = 32'd200; req_op0 = OP_ADD;
    req_valid = 2'b01;
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_out, req_ready} !== {1'b1, 1'b1, 32'd12, 2'b00}) begin
        errs++;
        $display("FAIL bp_hold_%0d got v=%b id=%b out=%0d rdy=%b exp v=1 id=1 out=12 rdy=00",
                 i, rsp_valid, rsp_id, rsp_out, req_ready);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== 3'b100) begin
      errs++;
      $display("FAIL bp_release got v=%b rdy=%b exp v=1 rdy=00", rsp_valid, req_ready);
    end
    cyc();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 3'b001) begin
      errs++;
      $display("FAIL bp_next got v=%b rdy=%b exp v=0 rdy=01", rsp_valid, req_ready);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    checks++;
    if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 1'b0, 32'd300}) begin
      errs++;
      $display("FAIL bp_second got v=%b id=%b out=%0d exp v=1 id=0 out=300",
               rsp_valid, rsp_id, rsp_out);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    if (ok) ok = 1'b1;
  endtask

  task automatic test_reset_exec;
    logic seen = 1'b0;
    req_a0 = 32'd7; req_b0 = 32'd8; req_op0 = OP_ADD;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zout} !== 6'b0
        || rsp_out !== 32'd0 || rsp_last !== RST_LAST) begin
      errs++;
      $display("FAIL rexec_outs got rdy=%b v=%b id=%b c=%b z=%b out=%h l=%b exp all reset",
               req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zout, rsp_out, rsp_last);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL rexec_norsp got=%b exp=0", seen);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL rexec_tie got=%b exp=01", req_ready);
    end
    req_valid = 2'b00;
    cyc();
  endtask

`ifdef ALU_SCHED_WIDE_EN
  task automatic test_wide_add;
    pulse_reset();
    req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = OP_ADD; req_cin = 2'b00;
    req_wide = 2'b00;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = OP_ADD;
    req_wide = 2'b10;
    req_a0 = 32'd9; req_b0 = 32'd9;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errs++;
      $display("FAIL wide_grant got=%b exp=10", req_ready);
    end
    cyc();
    req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = OP_AND;
    req_wide = 2'b00;
    cyc();
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_last, req_ready}
        !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 2'b00}) begin
      errs++;
      $display("FAIL wide_lo got v=%b id=%b out=%h c=%b l=%b rdy=%b exp v=1 id=1 out=0 c=1 l=0 rdy=00",
               rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_last, req_ready);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 2'b10) begin
      errs++;
      $display("FAIL wide_lock got=%b exp=10", req_ready);
    end
    cyc();
    req_valid = 2'b01;
    checks++;
    if (req_ready !== 2'b00) begin
      errs++;
      $display("FAIL wide_stall got=%b exp=00", req_ready);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_zout, rsp_last, req_ready}
        !== {1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 2'b00}) begin
      errs++;
      $display("FAIL wide_hi got v=%b id=%b out=%h c=%b z=%b l=%b rdy=%b exp v=1 id=1 out=1 c=0 z=0 l=1 rdy=00",
               rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_zout, rsp_last, req_ready);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL wide_after got=%b exp=01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    checks++;
    if ({rsp_id, rsp_out} !== {1'b0, 32'd18}) begin
      errs++;
      $display("FAIL wide_req0 got id=%b out=%0d exp id=0 out=18", rsp_id, rsp_out);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_wide_zero;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = OP_ADD;
    req_cin = 2'b00;
    req_wide = 2'b10;
    req_valid = 2'b10;
    cyc();
    req_b1 = 32'd0;
    req_wide = 2'b00;
    cyc();
    checks++;
    if ({rsp_valid, rsp_zout, rsp_last} !== 3'b110) begin
      errs++;
      $display("FAIL wzero_lo got v=%b z=%b l=%b exp v=1 z=1 l=0",
               rsp_valid, rsp_zout, rsp_last);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    cyc();
    req_valid = 2'b00;
    cyc();
    checks++;
    if ({rsp_valid, rsp_out, rsp_cout, rsp_zout, rsp_last}
        !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL wzero_hi got v=%b out=%h c=%b z=%b l=%b exp v=1 out=0 c=1 z=1 l=1",
               rsp_valid, rsp_out, rsp_cout, rsp_zout, rsp_last);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_fairness();
    test_backpressure();
    test_reset_exec();
`ifdef ALU_SCHED_WIDE_EN
    test_wide_add();
    test_wide_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
